// File: rtl/rdma_host_frame_tx_if.sv
// Port bundle for the host frame transmitter: work requests, payload stream,
// the DUT host port and the completion/credit status.
interface rdma_host_frame_tx_if;
    // Handshakes: a request or payload beat transfers on a rising clk edge where
    // valid && ready; the source holds its fields stable until that edge, and ready
    // never depends combinationally on valid. The host port has no ready.
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [23:0] req_qpn;
    logic [23:0] req_psn;
    logic [4:0]  req_len;

    logic        pay_valid;
    logic        pay_ready;
    logic [63:0] pay_data;

    logic        host_valid;
    logic [63:0] host_data;
    logic        host_last;

    logic        comp_valid;
    logic [2:0]  outstanding;
    logic        spurious_comp;
    logic        timeout_err;
    logic        payload_state;

    modport master (
        output req_valid, req_opcode, req_qpn, req_psn, req_len,
        output pay_valid, pay_data, comp_valid,
        input  req_ready, pay_ready, host_valid, host_data, host_last,
        input  outstanding, spurious_comp, timeout_err, payload_state
    );

    modport slave (
        input  req_valid, req_opcode, req_qpn, req_psn, req_len,
        input  pay_valid, pay_data, comp_valid,
        output req_ready, pay_ready, host_valid, host_data, host_last,
        output outstanding, spurious_comp, timeout_err, payload_state
    );
endinterface

// File: rtl/rdma_host_frame_tx.sv
// Host-side frame transmitter: one header beat then req_len payload beats per work
// request, with credit-limited outstanding frames and completion error tracking.
module rdma_host_frame_tx #(
    parameter int MAX_BEATS = 16,
    parameter int CREDITS   = 4,
    parameter int TIMEOUT   = 1024
) (
    input logic clk,
    input logic rst,
    rdma_host_frame_tx_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t      state;
    logic [4:0]  remaining;
    logic        host_valid_q;
    logic        host_last_q;
    logic [63:0] host_data_q;
    logic [2:0]  outstanding_q;
    logic [TW-1:0] tmo_cnt;
    logic        spurious_q;
    logic        timeout_q;

    logic [4:0]  len_clamped;
    logic        frame_done;
    logic [3:0]  committed;

    assign len_clamped = (bus.req_len > 5'(MAX_BEATS)) ? 5'(MAX_BEATS) : bus.req_len;
    assign frame_done  = host_valid_q && host_last_q;
    // A last beat on the wire this cycle already owns a credit even though
    // outstanding only counts it from the next cycle.
    assign committed   = {1'b0, outstanding_q} + {3'b000, frame_done};

    assign bus.req_ready     = (state == IDLE) && (committed < 4'(CREDITS));
    assign bus.pay_ready     = (state == PAYLOAD);
    assign bus.host_valid    = host_valid_q;
    assign bus.host_data     = host_data_q;
    assign bus.host_last     = host_last_q;
    assign bus.outstanding   = outstanding_q;
    assign bus.spurious_comp = spurious_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.payload_state = (state == PAYLOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            host_valid_q <= 1'b0;
            host_last_q  <= 1'b0;
            host_data_q  <= '0;
        end else begin
            host_valid_q <= 1'b0;
            host_last_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        host_valid_q <= 1'b1;
                        host_data_q  <= {bus.req_opcode, bus.req_qpn, bus.req_psn,
                                         3'b000, len_clamped};
                        host_last_q  <= (len_clamped == 5'd0);
                        if (len_clamped != 5'd0) begin
                            remaining <= len_clamped;
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.pay_valid) begin
                        host_valid_q <= 1'b1;
                        host_data_q  <= bus.pay_data;
                        host_last_q  <= (remaining == 5'd1);
                        remaining    <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            tmo_cnt       <= '0;
            spurious_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            if (frame_done && !bus.comp_valid) begin
                outstanding_q <= outstanding_q + 3'd1;
            end else if (!frame_done && bus.comp_valid) begin
                if (outstanding_q == 3'd0) begin
                    spurious_q <= 1'b1;
                end else begin
                    outstanding_q <= outstanding_q - 3'd1;
                end
            end

            if (outstanding_q == 3'd0 || bus.comp_valid) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TW'(TIMEOUT)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end
endmodule
